// File: rtl/log2_iter_if.sv
// Handshake bundle for log2_iter: ready/valid on the input side, valid/yumi on the result side.
// The producer/consumer uses the master modport; the log2 unit uses the slave modport.
interface log2_iter_if #(
  parameter int width_p = 32
);
  logic [width_p-1:0] data_i;
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_o;
  logic               exact_o;
  logic               zero_o;
  logic               v_o;
  logic               yumi_i;

  modport master (
    output data_i, v_i, yumi_i,
    input  ready_o, data_o, exact_o, zero_o, v_o
  );

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_o, data_o, exact_o, zero_o, v_o
  );
endinterface

// File: rtl/log2_iter.sv
// Iterative floor(log2(x)) unit: retires step_p bit positions per BUSY cycle and
// also flags exact powers of two and zero. step_p must be 1, 2 or 4 and divide width_p.
module log2_iter #(
  parameter int width_p = 32,
  parameter int step_p  = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  log2_iter_if.slave      io
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] val_q, val_d;
  logic [width_p-1:0] cnt_q, cnt_d;
  logic               exact_q, exact_d;
  logic               zero_q, zero_d;

  logic [width_p-1:0] val_shift;
  logic [width_p-1:0] low_msb;
  logic               accept;

  assign val_shift = val_q >> step_p;
  assign accept    = io.v_i & io.ready_o;

  // Highest set bit among the step_p bits left once the shift would empty val.
  always_comb begin
    low_msb = '0;
    for (int i = 0; i < step_p; i++) begin
      if (val_q[i]) low_msb = width_p'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    exact_d = exact_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          val_d   = io.data_i;
          cnt_d   = '0;
          zero_d  = (io.data_i == '0);
          exact_d = (io.data_i != '0) &&
                    ((io.data_i & (io.data_i - width_p'(1))) == '0);
          state_d = (io.data_i == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (val_shift != '0) begin
          val_d = val_shift;
          cnt_d = cnt_q + width_p'(step_p);
        end else begin
          cnt_d   = cnt_q + low_msb;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      exact_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      exact_q <= exact_d;
      zero_q  <= zero_d;
    end
  end

  // cnt is zero for a zero input, so data_o needs no separate masking.
  assign io.ready_o = (state_q == IDLE) & ~reset_i;
  assign io.v_o     = (state_q == DONE);
  assign io.data_o  = cnt_q;
  assign io.exact_o = exact_q;
  assign io.zero_o  = zero_q;

endmodule

// File: tb/tb_log2_iter.sv
// Directed bench for log2_iter: one instance with step_p=1, one with step_p=4,
// a vector table plus back-pressure and mid-operation reset sequences.
module tb_log2_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  log2_iter_if #(.width_p(32)) if1 ();
  log2_iter_if #(.width_p(32)) if4 ();

  log2_iter #(.width_p(32), .step_p(1)) u_dut1 (.clk_i(clk), .reset_i(rst), .io(if1.slave));
  log2_iter #(.width_p(32), .step_p(4)) u_dut4 (.clk_i(clk), .reset_i(rst), .io(if4.slave));

  logic        sel = 1'b0;   // 0 -> step_p=1 instance, 1 -> step_p=4 instance
  logic [31:0] data_drv = '0;
  logic        v_drv = 1'b0;
  logic        yumi_drv = 1'b0;

  assign if1.data_i = data_drv;
  assign if4.data_i = data_drv;
  assign if1.v_i    = v_drv & ~sel;
  assign if4.v_i    = v_drv & sel;
  assign if1.yumi_i = yumi_drv & ~sel;
  assign if4.yumi_i = yumi_drv & sel;

  logic        cur_v, cur_ready, cur_exact, cur_zero;
  logic [31:0] cur_data;
  assign cur_v     = sel ? if4.v_o     : if1.v_o;
  assign cur_ready = sel ? if4.ready_o : if1.ready_o;
  assign cur_exact = sel ? if4.exact_o : if1.exact_o;
  assign cur_zero  = sel ? if4.zero_o  : if1.zero_o;
  assign cur_data  = sel ? if4.data_o  : if1.data_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sel;
    logic [31:0] x;
    logic [31:0] exp_data;
    logic        exp_exact;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Consuming a result that is not valid is a protocol error on the bench side.
  always @(posedge clk) begin
    if (!rst && ((if1.yumi_i && !if1.v_o) || (if4.yumi_i && !if4.v_o))) begin
      errors++;
      $display("FAIL protocol: yumi_i asserted while v_o=0");
    end
  end

  // Presents x for one cycle, measures cycles until v_o, returns the measured latency.
  task automatic launch(input string name, input logic [31:0] x, output int lat);
    data_drv = x;
    v_drv    = 1'b1;
    check({name, " ready_at_accept"}, {31'b0, cur_ready}, 32'd1);
    tick();
    v_drv = 1'b0;
    lat   = 1;
    while (!cur_v && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string name);
    if (cur_v) begin
      yumi_drv = 1'b1;
      tick();
      yumi_drv = 1'b0;
    end
    check({name, " ready_after_yumi"}, {31'b0, cur_ready}, 32'd1);
    check({name, " v_after_yumi"}, {31'b0, cur_v}, 32'd0);
  endtask

  task automatic run(input string name, input logic [31:0] x, input logic [31:0] exp_data,
                     input logic exp_exact, input logic exp_zero, input int exp_lat);
    int lat;
    launch(name, x, lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " data"}, cur_data, exp_data);
    check({name, " exact"}, {31'b0, cur_exact}, {31'b0, exp_exact});
    check({name, " zero"}, {31'b0, cur_zero}, {31'b0, exp_zero});
    $display("txn step=%0d x=0x%08h data=%0d exact=%0d zero=%0d lat=%0d",
             sel ? 4 : 1, x, cur_data, cur_exact, cur_zero, lat);
    consume(name);
  endtask

  initial begin
    int lat;
    // latency = 1 + floor(L/step) + 1 for nonzero x, 1 for x==0
    vecs[0]  = '{1'b0, 32'h0000_0001, 32'd0,  1'b1, 1'b0, 2};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'd31, 1'b1, 1'b0, 33};
    vecs[2]  = '{1'b0, 32'h0000_00C0, 32'd7,  1'b0, 1'b0, 9};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'd0,  1'b0, 1'b1, 1};
    vecs[4]  = '{1'b0, 32'h0000_0003, 32'd1,  1'b0, 1'b0, 3};
    vecs[5]  = '{1'b1, 32'h0001_2345, 32'd16, 1'b0, 1'b0, 6};
    vecs[6]  = '{1'b1, 32'h0000_0008, 32'd3,  1'b1, 1'b0, 2};
    vecs[7]  = '{1'b1, 32'h0000_0000, 32'd0,  1'b0, 1'b1, 1};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'd31, 1'b1, 1'b0, 9};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 32'd31, 1'b0, 1'b0, 9};
    vecs[10] = '{1'b1, 32'h0000_0010, 32'd4,  1'b1, 1'b0, 3};

    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("reset ready", {31'b0, cur_ready}, 32'd0);
      check("reset v", {31'b0, cur_v}, 32'd0);
      check("reset data", cur_data, 32'd0);
      check("reset exact", {31'b0, cur_exact}, 32'd0);
      check("reset zero", {31'b0, cur_zero}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post-reset ready1", {31'b0, if1.ready_o}, 32'd1);
    check("post-reset ready4", {31'b0, if4.ready_o}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      sel = vecs[i].sel;
      #0;
      run($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp_data,
          vecs[i].exp_exact, vecs[i].exp_zero, vecs[i].exp_lat);
    end

    // Back-pressure: result held for 10 cycles while the producer keeps offering data.
    sel = 1'b0;
    #0;
    launch("bp", 32'h0000_0400, lat);
    check("bp latency", lat, 12);
    for (int k = 0; k < 10; k++) begin
      data_drv = 32'h0000_0005;
      v_drv    = k[0];
      check("bp v_hold", {31'b0, cur_v}, 32'd1);
      check("bp data_hold", cur_data, 32'd10);
      check("bp exact_hold", {31'b0, cur_exact}, 32'd1);
      check("bp ready_low", {31'b0, cur_ready}, 32'd0);
      tick();
    end
    v_drv = 1'b0;
    $display("txn step=1 x=0x00000400 data=%0d exact=%0d held=10", cur_data, cur_exact);
    consume("bp");
    tick();
    tick();
    check("bp no_stray_result", {31'b0, cur_v}, 32'd0);

    // Reset during the 5th BUSY cycle of a long operation.
    launch("rst_x", 32'hFFFF_FFFF, lat);
    // launch waits for v_o; restart cleanly and use a manual accept instead
    consume("rst_pre");
    data_drv = 32'hFFFF_FFFF;
    v_drv    = 1'b1;
    tick();
    v_drv = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    #0;
    check("rst ready_during", {31'b0, cur_ready}, 32'd0);
    tick();
    check("rst v", {31'b0, cur_v}, 32'd0);
    check("rst data", cur_data, 32'd0);
    rst = 1'b0;
    #1;
    check("rst ready_after", {31'b0, cur_ready}, 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (cur_v) seen++;
        tick();
      end
      check("rst no_result", seen, 0);
    end
    $display("txn step=1 x=0xFFFFFFFF aborted by reset");
    run("post_rst", 32'h0000_0002, 32'd1, 1'b1, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/log2_iter.md
Name: log2_iter

Overview:
- Iterative floor-log2 unit. Inverse of the pow2 exponent-to-value block.
- Takes a width_p-bit value and returns floor(log2(x)).
- Also reports whether x was an exact power of two, and whether x was zero.
- Uses the same ready/valid input and valid/yumi output handshake as pow2, so it drops into the same trace-replay bench with a 32-bit ring.

Parameters:
- width_p, 32, width of the input value and of data_o.
- step_p, 1, bit positions retired per BUSY cycle. Legal values are 1, 2 and 4. Values must divide width_p.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- data_i  input  width_p  value whose log2 is computed.
- v_i  input  1  data_i valid.
- ready_o  output  1  block can accept data_i this cycle.
- data_o  output  width_p  floor(log2(x)), zero-extended. Equals 0 when x==0.
- exact_o  output  1  x was a nonzero power of two.
- zero_o  output  1  x was zero (data_o is then meaningless and driven 0).
- v_o  output  1  result valid.
- yumi_i  input  1  consumer takes result. Legal only while v_o=1.

Behaviour:
- Single clock clk_i. Reset is synchronous and active-high on reset_i.
- Reset:
  - state goes to IDLE.
  - ready_o=1 once reset deasserts. ready_o=0 while reset_i=1.
  - v_o=0, data_o=0, exact_o=0, zero_o=0.
  - Internal value and count registers are cleared.
- States are IDLE, BUSY and DONE.
- ready_o = (state==IDLE) & ~reset_i. v_o = (state==DONE).
- IDLE:
  - Accept occurs on v_i & ready_o in cycle c.
  - On accept, latch val=data_i and cnt=0.
  - Latch exact = (x!=0) & ((x & (x-1))==0) and zero = (x==0).
  - If x==0, go to DONE; otherwise go to BUSY.
- BUSY, once per cycle:
  - If (val >> step_p) != 0: val <= val >> step_p, cnt <= cnt + step_p, stay in BUSY.
  - Otherwise: cnt <= cnt + msb_index(val[step_p-1:0]) and go to DONE. val is nonzero here by construction.
- Latency:
  - Let L = floor(log2 x). BUSY lasts B = floor(L/step_p) + 1 cycles.
  - v_o first rises in cycle c+1+B.
  - For x==0, B=0 and v_o rises in cycle c+1.
  - Worst case (step_p=1, MSB set): B=width_p.
- DONE:
  - data_o, exact_o and zero_o are driven from registers and stay stable while v_o=1, regardless of how long yumi_i is held low.
  - When yumi_i=1, go to IDLE. ready_o rises the next cycle; there is no same-cycle re-accept.
  - A new v_i during BUSY or DONE is not accepted. The producer holds it.
- Outputs after a result is consumed: data_o, exact_o and zero_o may retain their last value. Consumers must only sample them when v_o=1.
- Widths:
  - cnt is width_p bits wide. Its maximum value is width_p-1, so there is no overflow.
  - val shifts are logical right shifts.
- yumi_i while v_o=0 is a protocol error. The block ignores it; the bench asserts against it.
- reset_i in any state:
  - Aborts the operation on the next edge and returns to the reset values.
  - No result is emitted for the aborted input.
- Behaviour is fully defined for every width_p-bit input. There are no X-propagating paths from stale val/cnt to outputs.

Test Plan:
- step_p=1, x=0x00000001 accepted in cycle c -> v_o rises in c+2; data_o=0, exact_o=1, zero_o=0.
- step_p=1, x=0x80000000 -> v_o rises in c+33; data_o=31, exact_o=1. Then x=0x000000C0 -> data_o=7, exact_o=0.
- x=0 -> v_o rises in c+1; zero_o=1, data_o=0, exact_o=0. ready_o returns high the cycle after yumi_i.
- step_p=4, x=0x00012345 -> BUSY lasts 5 cycles; data_o=16 (0x10), exact_o=0. Also: x=0x00000008 -> data_o=3 after 1 BUSY cycle.
- Back-pressure: result for x=0x00000400 with yumi_i held low for 10 cycles -> v_o=1, data_o=10, exact_o=1 stable throughout. ready_o stays 0 and v_i pulses are not accepted.
- Reset mid-operation: step_p=1, x=0xFFFFFFFF, assert reset_i in the 5th BUSY cycle -> next cycle v_o=0, data_o=0, ready_o=1 after deassert, no result emitted. A following x=0x00000002 returns data_o=1.
